// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and helpers for the hazard/forwarding controller.
// Stage-entry bundle, forward-select width helper and common constants.
package hazard_pkg;

  localparam int RA_MAX = 8;
  localparam int FWD_RF = 0;

  typedef struct packed {
    logic              valid;
    logic [RA_MAX-1:0] rd;
    logic              regwrite;
    logic              load;
  } stage_t;

  localparam stage_t BUBBLE = '0;

  function automatic int fw_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/hazard_match.sv
// hazard_match: nearest-producer priority encoder over the shadow array.
// Loads below LOAD_MIN are treated as not yet usable and are skipped.
module hazard_match
  import hazard_pkg::*;
#(
  parameter int N        = 2,
  parameter int AW       = 5,
  parameter int LO       = 0,
  parameter int LOAD_MIN = 0,
  parameter int IW       = fw_width(N)
) (
  input  stage_t [N:0]    ents,
  input  logic   [AW-1:0] src,
  output logic            hit,
  output logic   [IW-1:0] idx,
  output logic            is_load
);

  // scan farthest to nearest so the nearest qualifying producer wins
  always_comb begin
    hit     = 1'b0;
    idx     = '0;
    is_load = 1'b0;
    for (int k = N; k >= LO; k--) begin
      if (ents[k].valid && ents[k].regwrite &&
          ents[k].rd == RA_MAX'(src) && src != '0 &&
          !(ents[k].load && k < LOAD_MIN)) begin
        hit     = 1'b1;
        idx     = IW'(k);
        is_load = ents[k].load;
      end
    end
  end

endmodule

// File: rtl/hazard_ctrl_n.sv
// hazard_ctrl_n: forwarding selects, load-use stalls, branch flushes,
// memory-wait freezes and saturating stall/flush counters.
module hazard_ctrl_n
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int NUM_FWD_STAGES = 2,
  parameter int LOAD_LATENCY   = 1,
  parameter int CNT_WIDTH      = 16,
  localparam int FW = fw_width(NUM_FWD_STAGES)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      issue_valid_i,
  input  logic [REG_ADDR_WIDTH-1:0] rs1D_i,
  input  logic [REG_ADDR_WIDTH-1:0] rs2D_i,
  input  logic [REG_ADDR_WIDTH-1:0] rdD_i,
  input  logic                      regwriteD_i,
  input  logic                      loadD_i,
  input  logic                      PCSrcE_i,
  input  logic                      mem_busy_i,
  output logic [FW-1:0]             ForwardAE_o,
  output logic [FW-1:0]             ForwardBE_o,
  output logic                      PCen_o,
  output logic                      Fen_o,
  output logic                      Den_o,
  output logic                      Frst_o,
  output logic                      Drst_o,
  output logic [CNT_WIDTH-1:0]      stall_cnt_o,
  output logic [CNT_WIDTH-1:0]      flush_cnt_o
);

  localparam int N  = NUM_FWD_STAGES;
  localparam int AW = REG_ADDR_WIDTH;

  stage_t [N:0]  ents;
  logic [AW-1:0] rs1E, rs2E;

  logic          h1e, h2e, h1d, h2d;
  logic          l1e, l2e, l1d, l2d;
  logic [FW-1:0] i1e, i2e, i1d, i2d;

  logic          flush, stall, lu;

  hazard_match #(
    .N(N), .AW(AW), .LO(1),
    .LOAD_MIN(LOAD_LATENCY + 1), .IW(FW)
  ) u_m1e (
    .ents(ents), .src(rs1E),
    .hit(h1e), .idx(i1e), .is_load(l1e)
  );

  hazard_match #(
    .N(N), .AW(AW), .LO(1),
    .LOAD_MIN(LOAD_LATENCY + 1), .IW(FW)
  ) u_m2e (
    .ents(ents), .src(rs2E),
    .hit(h2e), .idx(i2e), .is_load(l2e)
  );

  hazard_match #(
    .N(N), .AW(AW), .LO(0),
    .LOAD_MIN(0), .IW(FW)
  ) u_m1d (
    .ents(ents), .src(rs1D_i),
    .hit(h1d), .idx(i1d), .is_load(l1d)
  );

  hazard_match #(
    .N(N), .AW(AW), .LO(0),
    .LOAD_MIN(0), .IW(FW)
  ) u_m2d (
    .ents(ents), .src(rs2D_i),
    .hit(h2d), .idx(i2d), .is_load(l2d)
  );

  // forward selects from the nearest forwardable producer
  always_comb begin
    ForwardAE_o = FW'(FWD_RF);
    ForwardBE_o = FW'(FWD_RF);
    if (h1e && (!l1e || int'(i1e) > LOAD_LATENCY))
      ForwardAE_o = i1e;
    if (h2e && (!l2e || int'(i2e) > LOAD_LATENCY))
      ForwardBE_o = i2e;
  end

  // busy > branch flush > load-use stall > run
  always_comb begin
    lu = issue_valid_i &&
         ((h1d && l1d && int'(i1d) < LOAD_LATENCY) ||
          (h2d && l2d && int'(i2d) < LOAD_LATENCY));
    flush  = !mem_busy_i && PCSrcE_i;
    stall  = !mem_busy_i && !PCSrcE_i && lu;
    PCen_o = !mem_busy_i && !stall;
    Fen_o  = !mem_busy_i && !stall;
    Den_o  = !mem_busy_i && !stall;
    Frst_o = flush;
    Drst_o = flush;
  end

  // shadow array and EX source registers advance unless memory is busy
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ents <= '0;
      rs1E <= '0;
      rs2E <= '0;
    end else if (!mem_busy_i) begin
      for (int k = 1; k <= N; k++)
        ents[k] <= ents[k-1];
      if (flush || stall) begin
        ents[0] <= BUBBLE;
        rs1E    <= '0;
        rs2E    <= '0;
      end else begin
        ents[0] <= '{valid:    issue_valid_i,
                     rd:       RA_MAX'(rdD_i),
                     regwrite: regwriteD_i,
                     load:     loadD_i};
        rs1E    <= rs1D_i;
        rs2E    <= rs2D_i;
      end
    end
  end

  // saturating event counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      if (stall && stall_cnt_o != '1)
        stall_cnt_o <= stall_cnt_o + CNT_WIDTH'(1);
      if (flush && flush_cnt_o != '1)
        flush_cnt_o <= flush_cnt_o + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl_n.sv
// tb_hazard_ctrl_n: scoreboard bench for hazard_ctrl_n.
// Default-parameter instance plus a 3-stage / latency-2 / 2-bit-counter one.
module tb_hazard_ctrl_n;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       iv, rw, ld, pcs, busy;
  logic [4:0] rs1, rs2, rd;

  logic [1:0]  a_fa, a_fb;
  logic        a_pc, a_fe, a_de, a_fr, a_dr;
  logic [15:0] a_sc, a_fc;

  logic [1:0]  b_fa, b_fb;
  logic        b_pc, b_fe, b_de, b_fr, b_dr;
  logic [1:0]  b_sc, b_fc;

  int nvec = 0;
  int nmis = 0;

  typedef struct {
    string tag;
    int    sel;
    int    val;
  } sb_t;

  sb_t sb[$];

  always #5 clk = ~clk;

  hazard_ctrl_n u_a (
    .clk(clk), .rst(rst),
    .issue_valid_i(iv),
    .rs1D_i(rs1), .rs2D_i(rs2), .rdD_i(rd),
    .regwriteD_i(rw), .loadD_i(ld),
    .PCSrcE_i(pcs), .mem_busy_i(busy),
    .ForwardAE_o(a_fa), .ForwardBE_o(a_fb),
    .PCen_o(a_pc), .Fen_o(a_fe), .Den_o(a_de),
    .Frst_o(a_fr), .Drst_o(a_dr),
    .stall_cnt_o(a_sc), .flush_cnt_o(a_fc)
  );

  hazard_ctrl_n #(
    .NUM_FWD_STAGES(3), .LOAD_LATENCY(2), .CNT_WIDTH(2)
  ) u_b (
    .clk(clk), .rst(rst),
    .issue_valid_i(iv),
    .rs1D_i(rs1), .rs2D_i(rs2), .rdD_i(rd),
    .regwriteD_i(rw), .loadD_i(ld),
    .PCSrcE_i(pcs), .mem_busy_i(busy),
    .ForwardAE_o(b_fa), .ForwardBE_o(b_fb),
    .PCen_o(b_pc), .Fen_o(b_fe), .Den_o(b_de),
    .Frst_o(b_fr), .Drst_o(b_dr),
    .stall_cnt_o(b_sc), .flush_cnt_o(b_fc)
  );

  localparam int FA = 0, FB = 1, EN = 2, FL = 3, SC = 4, FC = 5;
  localparam int B = 8;

  function automatic int obs(input int sel);
    case (sel)
      FA:     return int'(a_fa);
      FB:     return int'(a_fb);
      EN:     return int'({a_pc, a_fe, a_de});
      FL:     return int'({a_fr, a_dr});
      SC:     return int'(a_sc);
      FC:     return int'(a_fc);
      B + FA: return int'(b_fa);
      B + FB: return int'(b_fb);
      B + EN: return int'({b_pc, b_fe, b_de});
      B + FL: return int'({b_fr, b_dr});
      B + SC: return int'(b_sc);
      B + FC: return int'(b_fc);
      default: return -1;
    endcase
  endfunction

  task automatic chk(input string tag, input int o, input int e);
    nvec++;
    if (o !== e) begin
      nmis++;
      $display("FAIL %s: got %0d, want %0d", tag, o, e);
    end
  endtask

  task automatic want(input string t, input int s, input int v);
    sb_t e;
    e.tag = t;
    e.sel = s;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic drain();
    sb_t e;
    #2;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk(e.tag, obs(e.sel), e.val);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic dr(input logic v, input logic [4:0] s1,
                    input logic [4:0] s2, input logic [4:0] d,
                    input logic w, input logic l);
    iv  = v;
    rs1 = s1;
    rs2 = s2;
    rd  = d;
    rw  = w;
    ld  = l;
  endtask

  task automatic nop();
    dr(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
  endtask

  initial begin
    nop();
    pcs  = 1'b0;
    busy = 1'b0;
    #12;
    want("rst_fa", FA, 0);
    want("rst_fb", FB, 0);
    want("rst_en", EN, 7);
    want("rst_fl", FL, 0);
    want("rst_sc", SC, 0);
    want("rst_fc", FC, 0);
    drain();
    rst = 1'b1;
    tick();

    // ALU chain, distance 1
    dr(1, 5'd1, 5'd2, 5'd5, 1, 0);
    want("alu_c1_en", EN, 7);
    drain(); tick();
    dr(1, 5'd5, 5'd1, 5'd7, 1, 0);
    want("alu_c2_en", EN, 7);
    drain(); tick();
    nop();
    want("fwd_d1_a", FA, 1);
    want("fwd_d1_b", FB, 0);
    drain(); tick();

    // ALU chain, distance 2
    dr(1, 5'd1, 5'd2, 5'd5, 1, 0);
    drain(); tick();
    dr(1, 5'd2, 5'd3, 5'd9, 1, 0);
    drain(); tick();
    dr(1, 5'd5, 5'd1, 5'd7, 1, 0);
    drain(); tick();
    nop();
    want("fwd_d2_a", FA, 2);
    drain(); tick();

    // x0 destination (a load) never forwards nor stalls
    dr(1, 5'd1, 5'd2, 5'd0, 1, 1);
    drain(); tick();
    dr(1, 5'd0, 5'd0, 5'd8, 1, 0);
    want("x0_en", EN, 7);
    want("x0_sc", SC, 0);
    drain(); tick();
    nop();
    want("x0_fa", FA, 0);
    drain(); tick();

    // load-use
    dr(1, 5'd2, 5'd0, 5'd6, 1, 1);
    drain(); tick();
    dr(1, 5'd3, 5'd6, 5'd10, 1, 0);
    want("lu_en", EN, 0);
    want("lu_fl", FL, 0);
    want("lu_sc0", SC, 0);
    drain(); tick();
    want("lu_rel_en", EN, 7);
    want("lu_sc1", SC, 1);
    want("lu_bub_fb", FB, 0);
    drain(); tick();
    nop();
    want("lu_fb", FB, 2);
    want("lu_fa", FA, 0);
    drain(); tick();

    // branch with simultaneous load-use
    dr(1, 5'd1, 5'd0, 5'd11, 1, 1);
    drain(); tick();
    dr(1, 5'd11, 5'd0, 5'd12, 1, 0);
    pcs = 1'b1;
    want("br_en", EN, 7);
    want("br_fl", FL, 3);
    want("br_fc0", FC, 0);
    drain(); tick();
    pcs = 1'b0;
    nop();
    want("br_fc1", FC, 1);
    want("br_sc", SC, 1);
    want("br_fl_off", FL, 0);
    drain(); tick();

    // memory freeze with a pending branch
    dr(1, 5'd1, 5'd2, 5'd12, 1, 0);
    drain(); tick();
    dr(1, 5'd12, 5'd0, 5'd13, 1, 0);
    drain(); tick();
    nop();
    busy = 1'b1;
    pcs  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      want("busy_fa", FA, 1);
      want("busy_en", EN, 0);
      want("busy_fl", FL, 0);
      want("busy_fc", FC, 1);
      drain(); tick();
    end
    busy = 1'b0;
    want("post_fa", FA, 1);
    want("post_fl", FL, 3);
    want("post_en", EN, 7);
    drain(); tick();
    pcs = 1'b0;
    want("post_fc", FC, 2);
    want("post_sc", SC, 1);
    want("post_bub", FA, 0);
    drain(); tick();

    // reset mid-stall
    dr(1, 5'd1, 5'd0, 5'd15, 1, 1);
    drain(); tick();
    dr(1, 5'd15, 5'd0, 5'd16, 1, 0);
    want("pre_rst_en", EN, 0);
    drain();
    rst = 1'b0;
    want("mrst_en", EN, 7);
    want("mrst_fa", FA, 0);
    want("mrst_fb", FB, 0);
    want("mrst_fl", FL, 0);
    want("mrst_sc", SC, 0);
    want("mrst_fc", FC, 0);
    want("mrst_bsc", B + SC, 0);
    drain(); tick();
    nop();
    #2;
    rst = 1'b1;
    tick();

    // alternate parameters: two stalls per load, saturation
    dr(1, 5'd1, 5'd0, 5'd6, 1, 1);
    drain(); tick();
    dr(1, 5'd3, 5'd6, 5'd7, 1, 0);
    want("b_st1_en", B + EN, 0);
    want("b_st1_sc", B + SC, 0);
    drain(); tick();
    want("b_st2_en", B + EN, 0);
    want("b_st2_sc", B + SC, 1);
    drain(); tick();
    want("b_rel_en", B + EN, 7);
    want("b_rel_sc", B + SC, 2);
    drain(); tick();
    dr(1, 5'd1, 5'd0, 5'd6, 1, 1);
    want("b_fb3", B + FB, 3);
    drain(); tick();
    dr(1, 5'd3, 5'd6, 5'd7, 1, 0);
    want("b_st3_en", B + EN, 0);
    want("b_st3_sc", B + SC, 2);
    drain(); tick();
    want("b_st4_en", B + EN, 0);
    want("b_st4_sc", B + SC, 3);
    drain(); tick();
    want("b_sat_sc", B + SC, 3);
    want("b_sat_en", B + EN, 7);
    drain(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl_n.md
# hazard_ctrl_n

- Parametrised hazard and forwarding controller for the pipelined core.
- Keeps its own shadow of destination-register state for the EX stage and the NUM_FWD_STAGES stages after it.
- Generates per-operand forwarding selects, load-use stalls, branch flushes and global memory-wait freezes.
- Keeps saturating stall/flush performance counters; it sits beside the datapath stage tops and drives their enable and flush inputs.

## Interface
Parameters:
- REG_ADDR_WIDTH, 5, register index width
- NUM_FWD_STAGES, 2, producer stages after EX usable as forward sources (min 1; 1 = MEM, 2 = WB, ...)
- LOAD_LATENCY, 1, stages after EX before load data becomes forwardable (1 ≤ LOAD_LATENCY ≤ NUM_FWD_STAGES)
- CNT_WIDTH, 16, performance counter width

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-low
- issue_valid_i  in  1  instruction in DECODE is valid
- rs1D_i, rs2D_i  in  REG_ADDR_WIDTH  DECODE source registers
- rdD_i  in  REG_ADDR_WIDTH  DECODE destination
- regwriteD_i  in  1  DECODE instruction writes the register file
- loadD_i  in  1  DECODE instruction is a load
- PCSrcE_i  in  1  branch/jump taken, resolved in EX
- mem_busy_i  in  1  data memory not ready; freezes the pipeline
- ForwardAE_o, ForwardBE_o  out  FW = $clog2(NUM_FWD_STAGES+1)  0 = register file, k = stage EX+k
- PCen_o, Fen_o, Den_o  out  1  stage enables, active-high
- Frst_o, Drst_o  out  1  FETCH/DECODE register flush, active-high
- stall_cnt_o, flush_cnt_o  out  CNT_WIDTH  saturating event counters

## Operation
- Shadow array entry[0..NUM_FWD_STAGES]: fields valid, rd, regwrite, load.
  - entry[0] is EX; entry[k] is EX+k.
- Registers rs1E and rs2E hold EX source registers.
- Producer match for source s at index k: valid & regwrite & rd == s & rd != 0.
- Forwarding:
  - ForwardXE = smallest k in 1..NUM_FWD_STAGES that matches rs1E/rs2E and is forwardable.
  - If no such k, the select is 0.
  - Forwardable: not a load, or a load with k ≥ LOAD_LATENCY+1.
- Load-use: the nearest match for rs1D_i or rs2D_i (when issue_valid_i) over k = 0..NUM_FWD_STAGES is a load with k < LOAD_LATENCY.
- Priority, highest first:
  1. mem_busy_i: PCen = Fen = Den = 0, Frst = Drst = 0. Shadow array, rs1E/rs2E and counters are frozen. A pending PCSrcE_i is held off until busy drops.
  2. PCSrcE_i: enables = 1, Frst = Drst = 1, entry[0] ← bubble, flush_cnt +1. Load-use is ignored.
  3. Load-use: PCen = Fen = Den = 0, entry[0] ← bubble, stall_cnt +1.
  4. Otherwise: enables = 1, flushes = 0, entry[0] ← {issue_valid_i, rdD_i, regwriteD_i, loadD_i}, rs1E/rs2E ← rs1D_i/rs2D_i.
- On every non-busy cycle, entry[k] ← entry[k-1] for k ≥ 1.
- Bubble = valid 0. A bubble clears rs1E/rs2E to 0.
- Counters saturate at all-ones and never wrap.

## Timing
- All control outputs are combinational from current state and inputs, and are valid in the same cycle.
- Shadow array, rs registers and counters update on rising clk.
- Reset asserted, whenever it happens (including mid-stall or mid-flush):
  - all entries invalid, rs1E = rs2E = 0, counters 0
  - ForwardAE = ForwardBE = 0
  - PCen = Fen = Den = 1, Frst = Drst = 0 (unless inputs demand otherwise combinationally)
- Load-use with default parameters costs exactly one stall cycle; the consumer enters EX with select 2.
- A flush costs one cycle of outputs; the bubble reaches EX+1 one cycle later.
- A stall of one cycle increments stall_cnt once. A busy cycle increments nothing.

## Structure
- Shared package hazard_pkg holds:
  - stage-entry struct type
  - FW localparam function
  - FWD_RF = 0 constant
  - bubble constant
- Sub-module hazard_match: nearest-producer priority encoder returning {hit, index, is_load}.
  - Four instances: rs1E, rs2E, rs1D, rs2D.
- Top holds the shadow array, priority logic and counters.

## Test plan
1. **Reset:** drop rst mid-run with entries valid → selects 0, enables 1, flushes 0, counters 0, all entries invalid.
2. **ALU chain:** `add x5` followed directly by `sub x7,x5,x1` → ForwardAE = 1; with one instruction between → ForwardAE = 2; with x0 as destination → 0 and no stall.
3. **Load-use:** `lw x6` in EX, DECODE rs2 = x6 → PCen = Fen = Den = 0 for one cycle, bubble in EX. Next cycle the consumer in EX has ForwardBE = 2 and stall_cnt = 1.
4. **Branch with simultaneous load-use:** PCSrcE_i = 1 → Frst = Drst = 1, no stall, flush_cnt = 1, EX bubble on the next cycle.
5. **Memory freeze:** mem_busy_i high for 3 cycles with ForwardAE = 1 → enables 0 and ForwardAE held at 1 throughout, state unchanged. A PCSrcE_i held during busy produces its flush in the first non-busy cycle.
6. **Alternate parameters and saturation:** NUM_FWD_STAGES = 3, LOAD_LATENCY = 2, CNT_WIDTH = 2 → load consumer stalls 2 cycles, forwards from k = 3, and stall_cnt saturates at 3 after four stalls.
